// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - instruction fetch stage: PC, single-outstanding imem requests, IF/ID register
`timescale 1ns/1ps
module inst_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall_d,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] id_inst
);
   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   logic [1:0]  state;
   logic [31:0] pc;
   logic        kill;
   logic        skid_valid;
   logic [31:0] skid_pc;
   logic [31:0] skid_inst;

   logic        req_hs;
   logic        id_free;
   logic        load_rsp;
   logic        load_skid;
   logic [31:0] fetch_pc;

   assign imem_req_valid = (state == S_REQ);
   assign imem_req_addr  = pc;
   assign req_hs         = imem_req_valid & imem_req_ready;
   assign id_free        = ~id_valid | ~stall_d;
   // pc has already stepped past the request that is outstanding
   assign fetch_pc       = pc - 32'd4;
   assign load_rsp       = (state == S_WAIT) & imem_rsp_valid & ~kill & ~redirect_valid & id_free;
   assign load_skid      = (state == S_FULL) & skid_valid & ~redirect_valid & id_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         kill       <= 1'b0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_inst  <= '0;
      end else if (redirect_valid) begin
         pc         <= {redirect_pc[31:2], 2'b00};
         skid_valid <= 1'b0;
         case (state)
            S_REQ: begin
               // a request accepted this cycle is for the old path
               if (req_hs) begin
                  state <= S_WAIT;
                  kill  <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  state <= S_REQ;
                  kill  <= 1'b0;
               end else begin
                  kill  <= 1'b1;
               end
            end
            default: state <= S_REQ;
         endcase
      end else begin
         case (state)
            S_REQ: begin
               if (req_hs) begin
                  pc    <= pc + 32'd4;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= S_REQ;
                  end else if (id_free) begin
                     state <= S_REQ;
                  end else begin
                     skid_valid <= 1'b1;
                     skid_pc    <= fetch_pc;
                     skid_inst  <= imem_rsp_data;
                     state      <= S_FULL;
                  end
               end
            end
            default: begin
               if (id_free) begin
                  skid_valid <= 1'b0;
                  state      <= S_REQ;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_pc_plus4 <= 32'd4;
         id_inst     <= NOP_INST;
      end else if (redirect_valid) begin
         id_valid <= 1'b0;
         id_inst  <= NOP_INST;
      end else if (load_rsp) begin
         id_valid    <= 1'b1;
         id_pc       <= fetch_pc;
         id_pc_plus4 <= fetch_pc + 32'd4;
         id_inst     <= imem_rsp_data;
      end else if (load_skid) begin
         id_valid    <= 1'b1;
         id_pc       <= skid_pc;
         id_pc_plus4 <= skid_pc + 32'd4;
         id_inst     <= skid_inst;
      end else if (id_free) begin
         id_valid <= 1'b0;
         id_inst  <= NOP_INST;
      end
   end
endmodule
